// File: rtl/sevenseg_capture.sv
// Captures a multiplexed active-low seven-segment display into a frame of hex nibbles.
// Each digit must hold steady for STABLE_CYCLES synchronized samples before it is accepted.
module sevenseg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] out_data,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_overrun
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  logic [6:0]              seg_s1_q, seg_s2_q, prev_seg_q;
  logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q, prev_an_q;
  logic [7:0]              cnt_q, cnt_d;
  logic                    acc_q, acc_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] stage_data_q, stage_data_d;
  logic [NUM_DIGITS-1:0]   stage_err_q, stage_err_d;
  logic [4*NUM_DIGITS-1:0] out_data_q;
  logic [NUM_DIGITS-1:0]   out_err_q;
  logic                    out_valid_q, out_overrun_q;

  logic       strobed, same_sample, window_new, accept, frame_done;
  logic [3:0] dec_nib;
  logic       dec_err;

  // Returns {err, nibble}; unknown patterns (blank included) give nibble 0 with err set.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an_in;
      an_s2_q  <= an_s1_q;
    end
  end

  assign strobed     = $onehot(~an_s2_q);
  assign same_sample = (seg_s2_q == prev_seg_q) && (an_s2_q == prev_an_q);
  assign window_new  = (an_s2_q != prev_an_q);
  assign {dec_err, dec_nib} = decode_seg(seg_s2_q);

  always_comb begin
    cnt_d = 8'd0;
    if (strobed) begin
      if (!same_sample)           cnt_d = 8'd1;
      else if (cnt_q == STABLE_C) cnt_d = cnt_q;
      else                        cnt_d = cnt_q + 8'd1;
    end
  end

  // A segment change inside a window restarts the count but must not re-accept.
  assign accept = strobed && (cnt_d == STABLE_C) && (cnt_q != STABLE_C)
                  && !(acc_q && !window_new);
  assign acc_d  = window_new ? accept : (acc_q | accept);

  assign frame_done = &mask_q;

  always_comb begin
    mask_d       = frame_done ? '0 : mask_q;
    stage_data_d = stage_data_q;
    stage_err_d  = stage_err_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (accept && !an_s2_q[i]) begin
        stage_data_d[4*i +: 4] = dec_nib;
        stage_err_d[i]         = dec_err;
        mask_d[i]              = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_seg_q   <= '1;
      prev_an_q    <= '1;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      mask_q       <= '0;
      stage_data_q <= '0;
      stage_err_q  <= '0;
    end else begin
      prev_seg_q   <= seg_s2_q;
      prev_an_q    <= an_s2_q;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mask_q       <= mask_d;
      stage_data_q <= stage_data_d;
      stage_err_q  <= stage_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q    <= '0;
      out_err_q     <= '0;
      out_valid_q   <= 1'b0;
      out_overrun_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q   <= 1'b0;
        out_overrun_q <= 1'b0;
      end
      if (frame_done) begin
        if (!out_valid_q || out_ready) begin
          out_data_q  <= stage_data_q;
          out_err_q   <= stage_err_q;
          out_valid_q <= 1'b1;
        end else begin
          out_overrun_q <= 1'b1;
        end
      end
    end
  end

  assign out_data    = out_data_q;
  assign out_err     = out_err_q;
  assign out_valid   = out_valid_q;
  assign out_overrun = out_overrun_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture (4 digits, 4 stable cycles).
module tb_sevenseg_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] out_data;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        out_overrun;

  int total = 0;
  int bad   = 0;

  sevenseg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .out_overrun(out_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    tick(n);
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    drive(4'b1110, s0, 8);
    drive(4'b1101, s1, 8);
    drive(4'b1011, s2, 8);
    drive(4'b0111, s3, 8);
    drive(4'b1111, 7'h7F, 2);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    seg_in    = 7'h7F;
    an_in     = 4'b1111;
    out_ready = 1'b0;
    tick(3);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_overrun", 32'(out_overrun), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Basic frame with exact latency on the last digit
    drive(4'b1110, 7'h79, 8);
    drive(4'b1101, 7'h24, 8);
    drive(4'b1011, 7'h30, 8);
    drive(4'b0111, 7'h19, 6);
    chk("lat_before", 32'(out_valid), 32'd0);
    tick(1);
    chk("lat_at", 32'(out_valid), 32'd1);
    drive(4'b1111, 7'h7F, 4);
    chk("f1_data", 32'(out_data), 32'h4321);
    chk("f1_err", 32'(out_err), 32'h0);
    tick(5);
    chk("f1_hold_valid", 32'(out_valid), 32'd1);
    chk("f1_hold_data", 32'(out_data), 32'h4321);
    handshake();
    chk("f1_hs_valid", 32'(out_valid), 32'd0);

    // Blank digit 2
    frame(7'h79, 7'h24, 7'h7F, 7'h19);
    chk("blank_valid", 32'(out_valid), 32'd1);
    chk("blank_data", 32'(out_data), 32'h4021);
    chk("blank_err", 32'(out_err), 32'b0100);
    handshake();

    // Glitching digit 2 never accepted
    drive(4'b1110, 7'h79, 8);
    drive(4'b1101, 7'h24, 8);
    for (int k = 0; k < 4; k++) begin
      drive(4'b1011, 7'h30, 2);
      drive(4'b1011, 7'h40, 2);
    end
    drive(4'b0111, 7'h19, 8);
    drive(4'b1111, 7'h7F, 20);
    chk("glitch_valid", 32'(out_valid), 32'd0);
    drive(4'b1011, 7'h30, 8);
    drive(4'b1111, 7'h7F, 2);
    chk("glitch_fix_valid", 32'(out_valid), 32'd1);
    chk("glitch_fix_data", 32'(out_data), 32'h4321);
    handshake();

    // Overrun: second frame discarded
    frame(7'h79, 7'h24, 7'h30, 7'h19);
    chk("ovr_first_valid", 32'(out_valid), 32'd1);
    chk("ovr_first_ovr", 32'(out_overrun), 32'd0);
    frame(7'h02, 7'h78, 7'h00, 7'h10);
    chk("ovr_data_kept", 32'(out_data), 32'h4321);
    chk("ovr_flag", 32'(out_overrun), 32'd1);
    chk("ovr_valid", 32'(out_valid), 32'd1);
    handshake();
    chk("ovr_hs_valid", 32'(out_valid), 32'd0);
    chk("ovr_hs_flag", 32'(out_overrun), 32'd0);

    // Ready coincides with a new frame completing
    frame(7'h79, 7'h24, 7'h30, 7'h19);
    drive(4'b1110, 7'h08, 8);
    drive(4'b1101, 7'h03, 8);
    drive(4'b1011, 7'h46, 8);
    drive(4'b0111, 7'h21, 6);
    chk("coinc_pre_data", 32'(out_data), 32'h4321);
    handshake();
    chk("coinc_valid", 32'(out_valid), 32'd1);
    chk("coinc_data", 32'(out_data), 32'hDCBA);
    chk("coinc_ovr", 32'(out_overrun), 32'd0);
    drive(4'b1111, 7'h7F, 2);
    handshake();
    chk("coinc_hs_valid", 32'(out_valid), 32'd0);

    // Reset mid-frame
    drive(4'b1110, 7'h06, 8);
    drive(4'b1101, 7'h0E, 8);
    drive(4'b1111, 7'h7F, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", 32'(out_data), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    drive(4'b1011, 7'h40, 8);
    drive(4'b0111, 7'h12, 8);
    drive(4'b1111, 7'h7F, 10);
    chk("rst_partial_valid", 32'(out_valid), 32'd0);
    frame(7'h06, 7'h0E, 7'h40, 7'h12);
    chk("rst_full_valid", 32'(out_valid), 32'd1);
    chk("rst_full_data", 32'(out_data), 32'h50FE);
    chk("rst_full_err", 32'(out_err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
